// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for the CPU data-memory port. Accepts a
//               single load or store at a time through a request/ready
//               handshake, performs byte-strobed writes into an on-chip word
//               RAM, and returns full aligned load words through a
//               valid/ready response handshake. Request-accept and response
//               latencies are set by parameters so that the core pipeline can
//               be exercised under stall conditions.
//
// Ports       : clk             - clock, all state updates on the rising edge
//               rst             - synchronous active-high reset
//               Address         - byte address; [1:0] ignored, upper bits alias
//               MemWrite        - store request, held until accepted
//               Write_data      - store data, already lane-shifted
//               Write_strb      - byte enables for Write_data
//               MemRead         - load request, held until accepted
//               Mem_Req_Ready   - request accept (registered)
//               Read_data       - aligned load word (registered)
//               Read_data_Valid - load data valid (registered)
//               Read_data_Ready - initiator can take the load data
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH   = 12,
    parameter int REQ_LATENCY  = 2,
    parameter int RESP_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_depth = 1 << ADDR_WIDTH;

    // Countdown start values. A latency of N needs N idle cycles, and the
    // cycle in which the counter reads zero is itself one of them, hence -1.
    localparam logic [3:0] c_req_cnt_init  =
        (REQ_LATENCY  > 0) ? 4'(REQ_LATENCY  - 1) : 4'd0;
    localparam logic [3:0] c_resp_cnt_init =
        (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ_WAIT = 3'd1,
        S_REQ_RDY  = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------------
    logic [31:0] r_mem [0:c_depth-1];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic [31:0] r_rd_buf;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                  w_req;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_wr_en;
    logic [31:0]           w_rd_word;
    logic                  w_unused_addr;

    assign w_req = MemRead | MemWrite;
    assign w_idx = Address[ADDR_WIDTH+1:2];

    // Mem_Req_Ready is high exactly while in S_REQ_RDY, so a handshake is
    // simply "in S_REQ_RDY with a request present". A simultaneous read is
    // dropped in favour of the write. Reset wins over a coincident store.
    assign w_wr_en   = (r_state == S_REQ_RDY) && MemWrite && !rst;
    assign w_rd_word = r_mem[w_idx];

    // Byte-offset and high address bits intentionally do not reach the RAM;
    // addresses alias modulo the RAM size.
    assign w_unused_addr = &{1'b0, Address[31:ADDR_WIDTH+2], Address[1:0]};

    // ------------------------------------------------------------------------
    // RAM write port: per-byte strobes, contents never reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (Write_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= Write_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 32'd0;
            r_rd_buf    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (REQ_LATENCY == 0) begin
                            r_state     <= S_REQ_RDY;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state <= S_REQ_WAIT;
                            r_cnt   <= c_req_cnt_init;
                        end
                    end
                end

                S_REQ_WAIT: begin
                    if (!w_req) begin
                        // Initiator withdrew before we were ready.
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state     <= S_REQ_RDY;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_REQ_RDY: begin
                    // Ready drops after every handshake or withdrawal, which
                    // enforces at least one low cycle between accepts.
                    r_req_ready <= 1'b0;
                    if (!w_req || MemWrite) begin
                        // Withdrawn request, or a store (whose RAM update is
                        // done by the write port on this same edge).
                        r_state <= S_IDLE;
                    end else begin
                        r_rd_buf <= w_rd_word;
                        if (RESP_LATENCY == 0) begin
                            r_state    <= S_RESP;
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= w_rd_word;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= c_resp_cnt_init;
                        end
                    end
                end

                S_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_RESP;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= r_rd_buf;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    // Read_data keeps its value after the handshake; only the
                    // valid flag is withdrawn.
                    if (Read_data_Ready) begin
                        r_state    <= S_IDLE;
                        r_rd_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_rd_valid  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Mem_Req_Ready   = r_req_ready;
    assign Read_data_Valid = r_rd_valid;
    assign Read_data       = r_rd_data;

endmodule
`default_nettype wire
